// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : riscv_pkg                                                    |
// | Brief    : Shared encodings and FSM state type for the memory stage.    |
// | Revision : 1.0                                                         |
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  // Load funct3 encodings
  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  // Writeback select encodings
  localparam logic [1:0] c_wb_sel_alu  = 2'b00;
  localparam logic [1:0] c_wb_sel_load = 2'b01;
  localparam logic [1:0] c_wb_sel_pc4  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_REQ       = 2'd1,
    S_WAIT_RESP = 2'd2
  } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// | Module   : lsu_align                                                    |
// | Brief    : Store lane/byte-enable generation, misalignment detect and  |
// |            load extraction/extension.                                   |
// | Revision : 1.0                                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] load_data
);

  logic [31:0] w_lane;

  // Addressed byte/half moved down to bit 0
  assign w_lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    misaligned = 1'b0;
    load_data  = 32'h0;
    if (is_store) begin
      case (funct3)
        c_f3_sb: begin
          be    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        c_f3_sh: begin
          misaligned = addr_lo[0];
          be         = 4'b0011 << addr_lo;
          wdata      = {2{store_data[15:0]}};
        end
        c_f3_sw: begin
          misaligned = |addr_lo;
          be         = 4'b1111;
          wdata      = store_data;
        end
        default: misaligned = 1'b1;
      endcase
    end else begin
      case (funct3)
        c_f3_lb: begin
          be        = 4'b0001 << addr_lo;
          load_data = {{24{w_lane[7]}}, w_lane[7:0]};
        end
        c_f3_lbu: begin
          be        = 4'b0001 << addr_lo;
          load_data = {24'h0, w_lane[7:0]};
        end
        c_f3_lh: begin
          misaligned = addr_lo[0];
          be         = 4'b0011 << addr_lo;
          load_data  = {{16{w_lane[15]}}, w_lane[15:0]};
        end
        c_f3_lhu: begin
          misaligned = addr_lo[0];
          be         = 4'b0011 << addr_lo;
          load_data  = {16'h0, w_lane[15:0]};
        end
        c_f3_lw: begin
          misaligned = |addr_lo;
          be         = 4'b1111;
          load_data  = rdata;
        end
        default: misaligned = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// | Module   : mem_stage                                                    |
// | Brief    : RISC-V MEM stage: valid/ready data-bus access FSM, load     |
// |            alignment and the MEM/WB pipeline register.                  |
// | Revision : 1.0                                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [4:0]        rd_addr_in,
  input  logic              reg_write_en_in,
  input  logic [1:0]        mem_to_reg_in,
  input  logic [2:0]        funct3_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [DATA_W-1:0] pc_plus_4_in,
  output logic              mem_stall_out,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  output logic [3:0]        dmem_req_be,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_reg_write_en,
  output logic [1:0]        wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_load_data,
  output logic [DATA_W-1:0] wb_pc_plus_4,
  output logic              misalign_exc
);

  mem_state_e r_state;
  mem_state_e w_next_state;

  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_resp_done;
  logic        w_start;
  logic        w_exc;
  logic        w_retire;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  // Store flag wins when both load and store are set
  lsu_align u_lsu_align (
    .funct3     (funct3_in),
    .addr_lo    (alu_result_in[1:0]),
    .is_store   (mem_write_en_in),
    .store_data (store_data_in),
    .rdata      (dmem_resp_rdata),
    .be         (w_be),
    .wdata      (w_wdata),
    .misaligned (w_misaligned),
    .load_data  (w_load_data)
  );

  assign w_mem_op    = in_valid & (mem_read_en_in | mem_write_en_in);
  assign w_resp_done = (r_state == S_WAIT_RESP) & dmem_resp_valid;
  assign w_start     = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_exc       = (r_state == S_IDLE) & w_mem_op & w_misaligned;
  assign w_retire    = ((r_state == S_IDLE) & ~w_start) | w_resp_done;

  assign mem_stall_out = rst_n & w_mem_op & ~w_resp_done & ~w_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    dmem_req_valid = 1'b0;
    dmem_req_we    = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_wdata = '0;
    dmem_req_be    = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next_state = S_REQ;
      end
      S_REQ: begin
        dmem_req_valid = 1'b1;
        dmem_req_we    = mem_write_en_in;
        dmem_req_addr  = {alu_result_in[ADDR_W-1:2], 2'b00};
        dmem_req_wdata = w_wdata;
        dmem_req_be    = w_be;
        if (dmem_req_ready) w_next_state = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (dmem_resp_valid) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid        <= 1'b0;
      wb_reg_write_en <= 1'b0;
      misalign_exc    <= 1'b0;
      wb_rd_addr      <= '0;
      wb_mem_to_reg   <= '0;
      wb_alu_result   <= '0;
      wb_load_data    <= '0;
      wb_pc_plus_4    <= '0;
    end else begin
      wb_valid        <= w_retire & in_valid;
      wb_reg_write_en <= w_retire & in_valid & reg_write_en_in & ~w_exc;
      misalign_exc    <= w_exc;
      if (w_retire) begin
        wb_rd_addr    <= rd_addr_in;
        wb_mem_to_reg <= mem_to_reg_in;
        wb_alu_result <= alu_result_in;
        wb_load_data  <= w_resp_done ? w_load_data : '0;
        wb_pc_plus_4  <= pc_plus_4_in;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// | Module   : tb_mem_stage                                                 |
// | Brief    : Scoreboard bench for mem_stage with directed vectors.        |
// | Revision : 1.0                                                         |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] alu_result_in = '0;
  logic [31:0] store_data_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        reg_write_en_in = 1'b0;
  logic [1:0]  mem_to_reg_in = '0;
  logic [2:0]  funct3_in = '0;
  logic        mem_read_en_in = 1'b0;
  logic        mem_write_en_in = 1'b0;
  logic [31:0] pc_plus_4_in = '0;
  logic        mem_stall_out;
  logic        dmem_req_valid;
  logic        dmem_req_ready = 1'b1;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_be;
  logic        dmem_resp_valid = 1'b0;
  logic [31:0] dmem_resp_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write_en;
  logic [1:0]  wb_mem_to_reg;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_load_data;
  logic [31:0] wb_pc_plus_4;
  logic        misalign_exc;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .rd_addr_in(rd_addr_in), .reg_write_en_in(reg_write_en_in),
    .mem_to_reg_in(mem_to_reg_in), .funct3_in(funct3_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in),
    .pc_plus_4_in(pc_plus_4_in), .mem_stall_out(mem_stall_out),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_rdata(dmem_resp_rdata),
    .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .wb_reg_write_en(wb_reg_write_en), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
    .wb_pc_plus_4(wb_pc_plus_4), .misalign_exc(misalign_exc)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rwe;
    logic [1:0]  m2r;
    logic [31:0] alu;
    logic        chk_ld;
    logic [31:0] ld;
    logic [31:0] pc;
    logic        exc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        chk_w;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t     wb_q[$];
  req_exp_t    req_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  bit          hold_resp = 1'b0;
  bit          inject_resp = 1'b0;
  logic [31:0] rdata_next = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endfunction

  function automatic void push_wb(logic [4:0] rd, logic rwe, logic [1:0] m2r, logic [31:0] alu,
                                  logic chk_ld, logic [31:0] ld, logic [31:0] pc, logic exc);
    wb_exp_t e;
    e.rd = rd; e.rwe = rwe; e.m2r = m2r; e.alu = alu;
    e.chk_ld = chk_ld; e.ld = ld; e.pc = pc; e.exc = exc;
    wb_q.push_back(e);
  endfunction

  function automatic void push_req(logic we, logic [31:0] addr, logic chk_w, logic [3:0] be,
                                   logic [31:0] wdata);
    req_exp_t e;
    e.we = we; e.addr = addr; e.chk_w = chk_w; e.be = be; e.wdata = wdata;
    req_q.push_back(e);
  endfunction

  // Writeback monitor
  initial forever begin
    @(negedge clk);
    if (wb_valid) begin
      if (wb_q.size() == 0) begin
        n_total++;
        $display("FAIL wb_unexpected: wb_valid=1 rd=%0d, want no retire", wb_rd_addr);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        check("wb_rd_addr", wb_rd_addr, e.rd);
        check("wb_reg_write_en", wb_reg_write_en, e.rwe);
        check("wb_mem_to_reg", wb_mem_to_reg, e.m2r);
        check("wb_alu_result", wb_alu_result, e.alu);
        check("wb_pc_plus_4", wb_pc_plus_4, e.pc);
        check("misalign_exc", misalign_exc, e.exc);
        if (e.chk_ld) check("wb_load_data", wb_load_data, e.ld);
      end
    end else if (misalign_exc) begin
      n_total++;
      $display("FAIL exc_without_valid: misalign_exc=1 with wb_valid=0, want 0");
    end
  end

  // Request monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && dmem_req_valid && dmem_req_ready) begin
      if (req_q.size() == 0) begin
        n_total++;
        $display("FAIL req_unexpected: request addr=0x%08h, want none", dmem_req_addr);
      end else begin
        req_exp_t e;
        e = req_q.pop_front();
        check("req_we", dmem_req_we, e.we);
        check("req_addr", dmem_req_addr, e.addr);
        if (e.chk_w) begin
          check("req_be", dmem_req_be, e.be);
          check("req_wdata", dmem_req_wdata, e.wdata);
        end
      end
    end
  end

  // Memory responder: acknowledge on the cycle after acceptance
  initial forever begin
    bit pend;
    @(negedge clk);
    pend = (!hold_resp && rst_n && dmem_req_valid && dmem_req_ready) || inject_resp;
    @(posedge clk);
    #1;
    dmem_resp_valid = pend;
    dmem_resp_rdata = pend ? rdata_next : 32'h0;
  end

  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic rwe, input logic [1:0] m2r, input logic [2:0] f3,
                       input logic rd_en, input logic wr_en, input logic [31:0] pc,
                       input int delay, input int exp_stall, input logic [31:0] exp_addr);
    int stall_cnt = 0;
    int req_cycles = 0;
    bit done = 1'b0;
    in_valid = 1'b1; alu_result_in = alu; store_data_in = sd; rd_addr_in = rd;
    reg_write_en_in = rwe; mem_to_reg_in = m2r; funct3_in = f3;
    mem_read_en_in = rd_en; mem_write_en_in = wr_en; pc_plus_4_in = pc;
    dmem_req_ready = (delay == 0);
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (dmem_req_valid) begin
        req_cycles++;
        check("req_addr_stable", dmem_req_addr, exp_addr);
      end
      if (mem_stall_out) stall_cnt++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) dmem_req_ready = (req_cycles >= delay);
    end
    if (!done) begin
      n_total++;
      $display("FAIL stall_timeout: stall still high after 64 cycles, want release");
    end
    check("stall_cycles", stall_cnt, exp_stall);
    in_valid = 1'b0; mem_read_en_in = 1'b0; mem_write_en_in = 1'b0; reg_write_en_in = 1'b0;
    dmem_req_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_req_valid", dmem_req_valid, 0);
    check("rst_stall", mem_stall_out, 0);
    check("rst_exc", misalign_exc, 0);
    check("rst_wb_we", wb_reg_write_en, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU op
    push_wb(5, 1, c_wb_sel_alu, 32'h1234, 0, 0, 32'h104, 0);
    issue(32'h1234, 0, 5, 1, c_wb_sel_alu, 3'b000, 0, 0, 32'h104, 0, 0, 0);
    // SB at 0x1003
    rdata_next = 32'h0;
    push_req(1, 32'h1000, 1, 4'b1000, 32'hDDDDDDDD);
    push_wb(0, 0, c_wb_sel_alu, 32'h1003, 0, 0, 32'h108, 0);
    issue(32'h1003, 32'hAABBCCDD, 0, 0, c_wb_sel_alu, c_f3_sb, 0, 1, 32'h108, 0, 2, 32'h1000);
    // LB / LBU at 0x2001
    rdata_next = 32'h000080FF;
    push_req(0, 32'h2000, 0, 0, 0);
    push_wb(6, 1, c_wb_sel_load, 32'h2001, 1, 32'hFFFFFF80, 32'h10C, 0);
    issue(32'h2001, 0, 6, 1, c_wb_sel_load, c_f3_lb, 1, 0, 32'h10C, 0, 2, 32'h2000);
    push_req(0, 32'h2000, 0, 0, 0);
    push_wb(7, 1, c_wb_sel_load, 32'h2001, 1, 32'h00000080, 32'h110, 0);
    issue(32'h2001, 0, 7, 1, c_wb_sel_load, c_f3_lbu, 1, 0, 32'h110, 0, 2, 32'h2000);
    // LHU / LH at 0x2002
    rdata_next = 32'hBEEF0000;
    push_req(0, 32'h2000, 0, 0, 0);
    push_wb(8, 1, c_wb_sel_load, 32'h2002, 1, 32'h0000BEEF, 32'h114, 0);
    issue(32'h2002, 0, 8, 1, c_wb_sel_load, c_f3_lhu, 1, 0, 32'h114, 0, 2, 32'h2000);
    push_req(0, 32'h2000, 0, 0, 0);
    push_wb(9, 1, c_wb_sel_load, 32'h2002, 1, 32'hFFFFBEEF, 32'h118, 0);
    issue(32'h2002, 0, 9, 1, c_wb_sel_load, c_f3_lh, 1, 0, 32'h118, 0, 2, 32'h2000);
    // SH at 0x1002, SW at 0x1004
    push_req(1, 32'h1000, 1, 4'b1100, 32'h56785678);
    push_wb(0, 0, c_wb_sel_alu, 32'h1002, 0, 0, 32'h11C, 0);
    issue(32'h1002, 32'h12345678, 0, 0, c_wb_sel_alu, c_f3_sh, 0, 1, 32'h11C, 0, 2, 32'h1000);
    push_req(1, 32'h1004, 1, 4'b1111, 32'hCAFEF00D);
    push_wb(0, 0, c_wb_sel_alu, 32'h1004, 0, 0, 32'h120, 0);
    issue(32'h1004, 32'hCAFEF00D, 0, 0, c_wb_sel_alu, c_f3_sw, 0, 1, 32'h120, 0, 2, 32'h1004);
    // LW at 0x3000 with ready held low for 4 request cycles
    rdata_next = 32'h11223344;
    push_req(0, 32'h3000, 0, 0, 0);
    push_wb(10, 1, c_wb_sel_load, 32'h3000, 1, 32'h11223344, 32'h124, 0);
    issue(32'h3000, 0, 10, 1, c_wb_sel_load, c_f3_lw, 1, 0, 32'h124, 4, 6, 32'h3000);
    // Misaligned LW and SW: no request, one-cycle exception retire
    push_wb(11, 0, c_wb_sel_load, 32'h3002, 0, 0, 32'h128, 1);
    issue(32'h3002, 0, 11, 1, c_wb_sel_load, c_f3_lw, 1, 0, 32'h128, 0, 0, 32'h3000);
    push_wb(0, 0, c_wb_sel_alu, 32'h1001, 0, 0, 32'h12C, 1);
    issue(32'h1001, 32'h5, 0, 0, c_wb_sel_alu, c_f3_sw, 0, 1, 32'h12C, 0, 0, 32'h1000);
    // JAL-style PC+4 writeback
    push_wb(1, 1, c_wb_sel_pc4, 32'h0, 0, 0, 32'h40, 0);
    issue(32'h0, 0, 1, 1, c_wb_sel_pc4, 3'b000, 0, 0, 32'h40, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset while waiting on a response; the late response must be ignored
    hold_resp = 1'b1;
    push_req(0, 32'h3004, 0, 0, 0);
    in_valid = 1'b1; alu_result_in = 32'h3004; rd_addr_in = 12; reg_write_en_in = 1'b1;
    mem_to_reg_in = c_wb_sel_load; funct3_in = c_f3_lw; mem_read_en_in = 1'b1;
    dmem_req_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (dmem_req_valid) seen = 1'b1;
    end
    if (!seen) begin
      n_total++;
      $display("FAIL reset_req_timeout: no request seen, want one");
    end
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; mem_read_en_in = 1'b0; reg_write_en_in = 1'b0;
    @(negedge clk);
    check("rst2_stall", mem_stall_out, 0);
    check("rst2_req_valid", dmem_req_valid, 0);
    check("rst2_wb_valid", wb_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; hold_resp = 1'b0;
    rdata_next = 32'hDEADBEEF; inject_resp = 1'b1;
    @(negedge clk); #1 inject_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("late_resp_wb_valid", wb_valid, 0);
      check("late_resp_req_valid", dmem_req_valid, 0);
    end
    @(posedge clk); #1;

    // Stage recovers after reset
    push_wb(3, 1, c_wb_sel_alu, 32'h55AA, 0, 0, 32'h200, 0);
    issue(32'h55AA, 0, 3, 1, c_wb_sel_alu, 3'b000, 0, 0, 32'h200, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", req_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of the Execute stage.
- Consumes the EX/MEM register contents and performs loads/stores over a valid/ready data-memory bus.
- Aligns and extends load data, then drives the registered MEM/WB outputs.
- Raises a stall to the hazard unit while a memory transaction is outstanding.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM slot holds a real instruction; 0 = bubble
- alu_result_in  in  32  effective address, or ALU result for non-memory ops
- store_data_in  in  32  forwarded rs2 value for stores
- rd_addr_in  in  5  destination register
- reg_write_en_in  in  1  writes rd
- mem_to_reg_in  in  2  writeback select: 00 ALU, 01 load, 10 PC+4
- funct3_in  in  3  load/store size and sign
- mem_read_en_in  in  1  load
- mem_write_en_in  in  1  store
- pc_plus_4_in  in  32  return address for JAL/JALR
- mem_stall_out  out  1  freeze IF..EX/MEM this cycle
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = write
- dmem_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_req_wdata  out  32  lane-replicated store data
- dmem_req_be  out  4  byte enables
- dmem_resp_valid  in  1  response or write acknowledge
- dmem_resp_rdata  in  32  read word
- wb_valid  out  1  MEM/WB slot valid
- wb_rd_addr  out  5  registered rd
- wb_reg_write_en  out  1  registered write enable, gated by wb_valid and no exception
- wb_mem_to_reg  out  2  registered select
- wb_alu_result  out  32  registered ALU result
- wb_load_data  out  32  aligned and extended load data
- wb_pc_plus_4  out  32  registered PC+4
- misalign_exc  out  1  one-cycle pulse with the faulting wb_valid

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - Every output, including dmem_req_valid and mem_stall_out, is 0.
  - Any outstanding transaction is dropped.
  - A dmem_resp_valid arriving afterwards in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT_RESP.
- IDLE, non-memory instruction or bubble:
  - MEM/WB registers load next edge (1-cycle latency).
  - wb_valid = in_valid; mem_stall_out = 0.
- IDLE, mem op and aligned:
  - Go to REQ; mem_stall_out = 1 combinationally in the same cycle.
- REQ:
  - dmem_req_valid = 1; address, we, be and wdata come from the held EX/MEM inputs and stay stable until ready.
  - On valid&ready, go to WAIT_RESP.
  - Do not deassert valid before ready.
- WAIT_RESP:
  - dmem_req_valid = 0.
  - On dmem_resp_valid: load MEM/WB registers (load data via the align unit), return to IDLE, and drop mem_stall_out in that cycle so upstream advances on the same edge.
  - The response arrives no earlier than the cycle after acceptance.
- Stall rule: mem_stall_out = in_valid & (mem_read_en_in | mem_write_en_in) & ~(state==WAIT_RESP & dmem_resp_valid) & ~misaligned.
- Upstream holds all inputs stable while the stall is high.
- While stalled, wb_valid = 0 and wb_reg_write_en = 0, so WB sees bubbles.
- Minimum memory-op latency: 3 cycles (IDLE→REQ→WAIT_RESP→retire) with ready=1 and a next-cycle response.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No bus request is issued.
  - Retires in 1 cycle with wb_valid=1, misalign_exc=1, wb_reg_write_en=0.
- Store byte enables:
  - SB: be = 0001<<addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011<<addr[1:0], wdata = {2{half}}.
  - SW: be = 1111.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Lane is selected by addr[1:0].
- Unsupported funct3 on a memory op is treated as misaligned (exception, no access).
- Simultaneous load and store flags on one instruction are illegal; the store takes priority.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 load/store encodings (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB/SH/SW = 000/001/010)
  - mem_to_reg encodings
  - mem FSM state enum
- One combinational sub-module, lsu_align, provides:
  - byte-enable and wdata lane generation
  - misalignment detect
  - load extraction and extension
- The FSM and MEM/WB registers stay in mem_stage.

Test Plan:
- ALU op, in_valid=1, alu_result_in=0x1234, rd=5 → next edge wb_valid=1, wb_alu_result=0x1234, wb_rd_addr=5; mem_stall_out never high.
- SB at 0x1003, data 0xAABBCCDD, ready=1, ack next cycle → dmem_req_addr=0x1000, be=1000, wdata=0xDDDDDDDD; stall high for 2 cycles; wb_valid on cycle 3.
- LB at 0x2001, rdata=0x0000_80FF → wb_load_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x2002, rdata=0xBEEF0000 → 0x0000BEEF.
- LW at 0x3000, ready held 0 for 4 cycles → dmem_req_valid and addr stay stable; stall held for all cycles; retire one cycle after the response.
- LW at 0x3002 → no dmem_req_valid; misalign_exc=1, wb_valid=1, wb_reg_write_en=0 next edge.
- rst_n low while in WAIT_RESP, then a response arrives after release → outputs 0 and FSM in IDLE; the late response causes no wb_valid.
